control: RTL and testbench



---
 rtl/control_pkg.sv | 25 ++
 rtl/control.sv | 93 +++++++++
 tb/tb_control.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the shift-and-add multiplier control FSM.
//   STATE_W : width of the FSM state register (fixed at 2 bits)
//   state_e : FSM states with fixed encodings
//             S0 = idle, S1 = test/shift, S2 = post-add shift, S3 = done
// -----------------------------------------------------------------------------
package control_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  // Next state after the shift that finishes a multiplier bit: leave for the
  // done state once the counter says this was the last bit.
  function automatic state_e after_shift(input logic last_bit);
    return last_bit ? S3 : S1;
  endfunction

endpackage

// File: rtl/control.sv
// -----------------------------------------------------------------------------
// control
// Sequencing FSM for a sequential shift-and-add multiplier. Each multiplier bit
// costs one cycle (LSB=0: shift only) or two cycles (LSB=1: add, then shift).
//
// Ports
//   Clk   in  : system clock, rising-edge active
//   Reset in  : asynchronous active-high reset, forces state S0
//   K     in  : bit counter terminal flag (current bit is the last one)
//   St    in  : start request
//   M     in  : current multiplier LSB
//   Idle  out : waiting in S0 for St
//   Done  out : multiplication complete (one cycle, S3)
//   Load  out : load operands / clear accumulator
//   Sh    out : shift accumulator/multiplier right by one
//   Ad    out : add multiplicand into upper accumulator
//
// All outputs are Mealy: combinational from the state and St/M/K.
// -----------------------------------------------------------------------------
module control
  import control_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic K,
  input  logic St,
  input  logic M,
  output logic Idle,
  output logic Done,
  output logic Load,
  output logic Sh,
  output logic Ad
);

  state_e state;
  state_e state_d;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S0;
    end else begin
      state <= state_d;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d = state;
    Idle    = 1'b0;
    Done    = 1'b0;
    Load    = 1'b0;
    Sh      = 1'b0;
    Ad      = 1'b0;

    case (state)
      S0: begin
        Idle = 1'b1;
        if (St) begin
          Load    = 1'b1;
          state_d = S1;
        end
      end

      S1: begin
        // A set LSB takes an add cycle first; K only matters on the shift.
        if (M) begin
          Ad      = 1'b1;
          state_d = S2;
        end else begin
          Sh      = 1'b1;
          state_d = after_shift(K);
        end
      end

      S2: begin
        Sh      = 1'b1;
        state_d = after_shift(K);
      end

      S3: begin
        // St is deliberately ignored here so a held start cannot skip Idle.
        Done    = 1'b1;
        state_d = S0;
      end

      default: begin
        state_d = S0;
      end
    endcase
  end

endmodule

// File: tb/tb_control.sv
module tb_control;

  logic Clk, Reset, K, St, M;
  logic Idle, Done, Load, Sh, Ad;
  wire [4:0] outs = {Idle, Done, Load, Sh, Ad};

  int errors = 0;
  int checks = 0;

  control dut (
    .Clk(Clk), .Reset(Reset), .K(K), .St(St), .M(M),
    .Idle(Idle), .Done(Done), .Load(Load), .Sh(Sh), .Ad(Ad)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Output patterns {Idle,Done,Load,Sh,Ad}
  localparam logic [4:0] O_IDLE  = 5'b10000;
  localparam logic [4:0] O_START = 5'b10100;
  localparam logic [4:0] O_ADD   = 5'b00001;
  localparam logic [4:0] O_SHIFT = 5'b00010;
  localparam logic [4:0] O_DONE  = 5'b01000;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; St = 1'b0; M = 1'b0; K = 1'b0;
    #20;
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", dut.state); end
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); end
    Reset = 1'b0;
    step();
    step();
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL reset_hold_s0 got=%b exp=00", dut.state); end
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_hold_outs got=%b exp=%b", outs, O_IDLE); end
  endtask

  task automatic test_start();
    St = 1'b1; #2;
    checks++;
    if (outs !== O_START) begin errors++; $display("FAIL start_load got=%b exp=%b", outs, O_START); end
    step();
    St = 1'b0; M = 1'b0; K = 1'b0; #2;
    checks++;
    if (dut.state !== 2'b01) begin errors++; $display("FAIL start_state got=%b exp=01", dut.state); end
    checks++;
    if (Idle !== 1'b0 || Load !== 1'b0) begin
      errors++; $display("FAIL start_idle_load got=%b%b exp=00", Idle, Load);
    end
  endtask

  // Entered in S1
  task automatic test_add_path();
    M = 1'b1; K = 1'b0; #2;
    checks++;
    if (outs !== O_ADD) begin errors++; $display("FAIL add_strobe got=%b exp=%b", outs, O_ADD); end
    step();
    M = 1'b0; #2;
    checks++;
    if (dut.state !== 2'b10 || outs !== O_SHIFT) begin
      errors++; $display("FAIL add_s2 got=%b/%b exp=10/%b", dut.state, outs, O_SHIFT);
    end
    step(); #2;
    checks++;
    if (dut.state !== 2'b01) begin errors++; $display("FAIL add_back_s1 got=%b exp=01", dut.state); end
  endtask

  // Entered in S1, leaves in S0
  task automatic test_shift_path();
    M = 1'b0; K = 1'b0; #2;
    checks++;
    if (outs !== O_SHIFT) begin errors++; $display("FAIL shift_strobe got=%b exp=%b", outs, O_SHIFT); end
    step();
    checks++;
    if (dut.state !== 2'b01) begin errors++; $display("FAIL shift_stay_s1 got=%b exp=01", dut.state); end
    K = 1'b1; #2;
    checks++;
    if (outs !== O_SHIFT) begin errors++; $display("FAIL shift_last got=%b exp=%b", outs, O_SHIFT); end
    step();
    K = 1'b0; St = 1'b1; #2;
    checks++;
    if (dut.state !== 2'b11 || outs !== O_DONE) begin
      errors++; $display("FAIL shift_done got=%b/%b exp=11/%b", dut.state, outs, O_DONE);
    end
    step();
    St = 1'b0; #2;
    checks++;
    if (dut.state !== 2'b00 || outs !== O_IDLE) begin
      errors++; $display("FAIL shift_idle got=%b/%b exp=00/%b", dut.state, outs, O_IDLE);
    end
  endtask

  task automatic test_s2_exit();
    St = 1'b1; step(); St = 1'b0;
    M = 1'b1; step();
    M = 1'b0; K = 1'b1; #2;
    checks++;
    if (dut.state !== 2'b10 || outs !== O_SHIFT) begin
      errors++; $display("FAIL s2exit_shift got=%b/%b exp=10/%b", dut.state, outs, O_SHIFT);
    end
    step();
    K = 1'b0; #2;
    checks++;
    if (dut.state !== 2'b11 || outs !== O_DONE) begin
      errors++; $display("FAIL s2exit_done got=%b/%b exp=11/%b", dut.state, outs, O_DONE);
    end
    step();
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL s2exit_s0 got=%b exp=00", dut.state); end
  endtask

  task automatic test_full_sequence();
    // Per cycle: {St,M,K} applied, and the state expected during that cycle
    logic [2:0] stim [11];
    logic [1:0] exp_st [11];
    stim   = '{3'b100, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000,
               3'b011, 3'b001, 3'b000, 3'b100, 3'b000};
    exp_st = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
               2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 11; i++) begin
      {St, M, K} = stim[i];
      #2;
      checks++;
      if (dut.state !== exp_st[i]) begin
        errors++; $display("FAIL fullseq[%0d] got=%b exp=%b", i, dut.state, exp_st[i]);
      end
      if (i < 10) step();
    end
    // Now in S1 of a new run
    St = 1'b0; M = 1'b1; step();   // S2
    #4 Reset = 1'b1;
    #1;
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL async_reset got=%b exp=00", dut.state); end
    St = 1'b1; #1;
    checks++;
    if (outs !== O_START) begin errors++; $display("FAIL reset_load_follows got=%b exp=%b", outs, O_START); end
    step();
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL reset_held got=%b exp=00", dut.state); end
    St = 1'b0; M = 1'b0; Reset = 1'b0; #2;
    checks++;
    if (outs !== O_IDLE) begin errors++; $display("FAIL reset_release_outs got=%b exp=%b", outs, O_IDLE); end
    step();
    checks++;
    if (dut.state !== 2'b00) begin errors++; $display("FAIL reset_release_s0 got=%b exp=00", dut.state); end
  endtask

  // Drives a behavioural 4x4 shift-and-add datapath from the DUT strobes and
  // checks the product and the latency (bit-cycles + 1) for random operands.
  task automatic test_random();
    localparam int N = 4;
    logic [3:0] a, b;
    logic [8:0] acc;
    int cnt, bitcyc;
    logic [4:0] o;
    bit done_seen;
    for (int t = 0; t < 24; t++) begin
      if (t == 0)      begin a = 4'hF; b = 4'hF; end
      else if (t == 1) begin a = 4'h7; b = 4'h0; end
      else begin a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); end
      bitcyc = N + $countones(b);
      acc = '0; cnt = 0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 14 && !done_seen; cyc++) begin
        St = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        M  = acc[0];
        K  = (cnt == N - 1);
        #2;
        o = outs;
        checks++;
        if (o[1] && o[0]) begin errors++; $display("FAIL rnd_ad_sh_both t=%0d cyc=%0d", t, cyc); end
        checks++;
        if (o[2] !== (cyc == 0)) begin
          errors++; $display("FAIL rnd_load t=%0d cyc=%0d got=%b exp=%b", t, cyc, o[2], cyc == 0);
        end
        if (o[3]) begin
          done_seen = 1'b1;
          checks++;
          if (cyc != bitcyc + 1) begin
            errors++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, cyc, bitcyc + 1);
          end
          checks++;
          if (acc[7:0] !== 8'(a * b)) begin
            errors++; $display("FAIL rnd_product t=%0d got=%0d exp=%0d", t, acc[7:0], a * b);
          end
        end
        step();
        if (o[2]) begin acc = {5'b0, b}; cnt = 0; end
        if (o[0]) acc[8:4] = {1'b0, acc[7:4]} + {1'b0, a};
        if (o[1]) begin acc = acc >> 1; cnt++; end
      end
      checks++;
      if (!done_seen) begin errors++; $display("FAIL rnd_timeout t=%0d no Done", t); end
      St = 1'b0; #2;
      checks++;
      if (dut.state !== 2'b00 || Idle !== 1'b1) begin
        errors++; $display("FAIL rnd_back_idle t=%0d got=%b/%b exp=00/1", t, dut.state, Idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_add_path();
    test_shift_path();
    test_s2_exit();
    test_full_sequence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
